// File: rtl/p4_router_egress_demux_if.sv
// ---------------------------------------------------------------------------
// p4_router_egress_demux_if
// Purpose : bundles the single egress input stream and the NUM_PORTS output
//           streams of the egress demux into one interface.
// Signals : in_tdata/in_tkeep/in_tuser/in_tlast/in_tvalid/in_tready
//             - input stream, in_tuser carries the egress port select
//           out_tdata/out_tkeep/out_tlast/out_tvalid/out_tready
//             - per-port output streams, port i at slice i
// Modports: master - upstream source / downstream sinks (testbench side)
//           slave  - the demux itself
// ---------------------------------------------------------------------------
interface p4_router_egress_demux_if #(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_BYTES     = 8,
  parameter int PORT_SEL_WIDTH = 2
);
  logic [DATA_BYTES*8-1:0]           in_tdata;
  logic [DATA_BYTES-1:0]             in_tkeep;
  logic [PORT_SEL_WIDTH-1:0]         in_tuser;
  logic                              in_tlast;
  logic                              in_tvalid;
  logic                              in_tready;
  logic [NUM_PORTS*DATA_BYTES*8-1:0] out_tdata;
  logic [NUM_PORTS*DATA_BYTES-1:0]   out_tkeep;
  logic [NUM_PORTS-1:0]              out_tlast;
  logic [NUM_PORTS-1:0]              out_tvalid;
  logic [NUM_PORTS-1:0]              out_tready;

  modport master (
    output in_tdata, in_tkeep, in_tuser, in_tlast, in_tvalid,
    input  in_tready,
    input  out_tdata, out_tkeep, out_tlast, out_tvalid,
    output out_tready
  );

  modport slave (
    input  in_tdata, in_tkeep, in_tuser, in_tlast, in_tvalid,
    output in_tready,
    output out_tdata, out_tkeep, out_tlast, out_tvalid,
    input  out_tready
  );
endinterface

// File: rtl/p4_router_egress_demux.sv
// ---------------------------------------------------------------------------
// p4_router_egress_demux
// Purpose : frame-aware 1-to-N demultiplexer. The port select in in_tuser is
//           taken from the first beat of each frame and the whole frame is
//           steered to that output stream, or discarded whole when the port
//           is disabled or out of range.
// Ports   : core_clk_ifc     - clock, rising edge
//           core_areset_ifc  - asynchronous active-high reset
//           egr              - input stream and per-port output streams
//           port_enable      - per-port enable, sampled at start of frame
//           cnts_clear       - synchronous clear of all counters
//           fwd_pkt_cnt      - frames forwarded per port
//           dis_drop_cnt     - frames dropped per port because disabled
//           bad_sel_drop_cnt - frames dropped because select >= NUM_PORTS
// ---------------------------------------------------------------------------
module p4_router_egress_demux #(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_BYTES     = 8,
  parameter int PORT_SEL_WIDTH = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                           core_clk_ifc,
  input  logic                           core_areset_ifc,
  p4_router_egress_demux_if.slave        egr,
  input  logic [NUM_PORTS-1:0]           port_enable,
  input  logic                           cnts_clear,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] fwd_pkt_cnt,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] dis_drop_cnt,
  output logic [CNT_WIDTH-1:0]           bad_sel_drop_cnt
);

  generate
    if ((NUM_PORTS < 2) || (PORT_SEL_WIDTH < $clog2(NUM_PORTS))) begin : g_param_chk
      $error("p4_router_egress_demux: NUM_PORTS must be >= 2 and fit in PORT_SEL_WIDTH");
    end
  endgenerate

  localparam logic [PORT_SEL_WIDTH:0] LP_NUM_PORTS = (PORT_SEL_WIDTH+1)'(NUM_PORTS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FWD = 2'd1, S_DROP = 2'd2} state_t;

  state_t                                   r_state, w_state_nxt;
  logic [PORT_SEL_WIDTH-1:0]                r_sel, w_sel_nxt;
  logic                                     r_live;
  logic                                     w_sel_ok, w_sof_en, w_fwd, w_port_rdy;
  logic                                     w_in_tready, w_acc, w_idle, w_bad_inc;
  logic [PORT_SEL_WIDTH-1:0]                w_port;
  logic [NUM_PORTS-1:0]                     w_user_oh, w_port_oh, w_load;
  logic [NUM_PORTS-1:0]                     w_fwd_inc, w_dis_inc;
  logic [NUM_PORTS-1:0]                     r_vld, r_last;
  logic [NUM_PORTS-1:0][DATA_BYTES*8-1:0]   r_data;
  logic [NUM_PORTS-1:0][DATA_BYTES-1:0]     r_keep;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]      r_fwd_cnt, r_dis_cnt;
  logic [CNT_WIDTH-1:0]                     r_bad_cnt;

  // Saturating counter step; clear wins over a same-cycle increment.
  function automatic logic [CNT_WIDTH-1:0] f_cnt_next(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 inc,
    input logic                 clr
  );
    if (clr) begin
      return '0;
    end else if (inc && (cur != {CNT_WIDTH{1'b1}})) begin
      return cur + CNT_WIDTH'(1);
    end else begin
      return cur;
    end
  endfunction

  // Routing decision for the current beat and the resulting input ready.
  always_comb begin
    w_idle   = (r_state == S_IDLE);
    w_sel_ok = ({1'b0, egr.in_tuser} < LP_NUM_PORTS);
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_user_oh[i] = (egr.in_tuser == PORT_SEL_WIDTH'(i));
    end
    // An out-of-range select decodes to all zeros, so it never reads as enabled.
    w_sof_en = |(w_user_oh & port_enable);
    case (r_state)
      S_IDLE: begin
        w_port = egr.in_tuser;
        w_fwd  = w_sel_ok && w_sof_en;
      end
      S_FWD: begin
        w_port = r_sel;
        w_fwd  = 1'b1;
      end
      S_DROP: begin
        w_port = r_sel;
        w_fwd  = 1'b0;
      end
      default: begin
        w_port = r_sel;
        w_fwd  = 1'b0;
      end
    endcase
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_port_oh[i] = (w_port == PORT_SEL_WIDTH'(i));
    end
    // Ready only looks at the target port register, never at in_tvalid.
    w_port_rdy  = |(w_port_oh & (~r_vld | egr.out_tready));
    w_in_tready = r_live && (w_fwd ? w_port_rdy : 1'b1);
    w_acc       = egr.in_tvalid && w_in_tready;
    w_load      = (w_acc && w_fwd) ? w_port_oh : '0;
    w_fwd_inc   = w_load & {NUM_PORTS{egr.in_tlast}};
    w_dis_inc   = (w_acc && w_idle && w_sel_ok && !w_sof_en) ? w_user_oh : '0;
    w_bad_inc   = w_acc && w_idle && !w_sel_ok;
  end

  // Frame state machine next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    case (r_state)
      S_IDLE: begin
        if (w_acc && !egr.in_tlast) begin
          w_sel_nxt   = egr.in_tuser;
          w_state_nxt = w_fwd ? S_FWD : S_DROP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FWD, S_DROP: begin
        if (w_acc && egr.in_tlast) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, latched select, and the post-reset input enable.
  always_ff @(posedge core_clk_ifc or posedge core_areset_ifc) begin
    if (core_areset_ifc) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_live  <= 1'b1;
    end
  end

  // Per-port output registers; a load takes precedence over a drain.
  always_ff @(posedge core_clk_ifc or posedge core_areset_ifc) begin
    if (core_areset_ifc) begin
      r_vld  <= '0;
      r_last <= '0;
      r_data <= '0;
      r_keep <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_load[i]) begin
          r_vld[i]  <= 1'b1;
          r_last[i] <= egr.in_tlast;
          r_data[i] <= egr.in_tdata;
          r_keep[i] <= egr.in_tkeep;
        end else if (egr.out_tready[i]) begin
          r_vld[i]  <= 1'b0;
        end
      end
    end
  end

  // Frame counters.
  always_ff @(posedge core_clk_ifc or posedge core_areset_ifc) begin
    if (core_areset_ifc) begin
      r_fwd_cnt <= '0;
      r_dis_cnt <= '0;
      r_bad_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_fwd_cnt[i] <= f_cnt_next(r_fwd_cnt[i], w_fwd_inc[i], cnts_clear);
        r_dis_cnt[i] <= f_cnt_next(r_dis_cnt[i], w_dis_inc[i], cnts_clear);
      end
      r_bad_cnt <= f_cnt_next(r_bad_cnt, w_bad_inc, cnts_clear);
    end
  end

  assign egr.in_tready     = w_in_tready;
  assign egr.out_tvalid    = r_vld;
  assign egr.out_tlast     = r_last;
  assign egr.out_tdata     = r_data;
  assign egr.out_tkeep     = r_keep;
  assign fwd_pkt_cnt       = r_fwd_cnt;
  assign dis_drop_cnt      = r_dis_cnt;
  assign bad_sel_drop_cnt  = r_bad_cnt;

endmodule

// File: tb/tb_p4_router_egress_demux.sv
// ---------------------------------------------------------------------------
// tb_p4_router_egress_demux
// Directed bench for the egress demux. Instance A uses the default
// configuration; instance B has 3 ports and 2-bit counters so that the
// out-of-range select and counter saturation can be reached quickly.
// ---------------------------------------------------------------------------
module tb_p4_router_egress_demux;
  localparam int DB   = 8;
  localparam int NP_A = 4;
  localparam int NP_B = 3;
  localparam int PSW  = 2;
  localparam int CW_A = 32;
  localparam int CW_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic [NP_A-1:0]      en_a;
  logic [NP_B-1:0]      en_b;
  logic                 clr_a, clr_b;
  logic [NP_A*CW_A-1:0] fwd_a, dis_a;
  logic [CW_A-1:0]      bad_a;
  logic [NP_B*CW_B-1:0] fwd_b, dis_b;
  logic [CW_B-1:0]      bad_b;

  p4_router_egress_demux_if #(.NUM_PORTS(NP_A), .DATA_BYTES(DB), .PORT_SEL_WIDTH(PSW)) ifa();
  p4_router_egress_demux_if #(.NUM_PORTS(NP_B), .DATA_BYTES(DB), .PORT_SEL_WIDTH(PSW)) ifb();

  p4_router_egress_demux #(.NUM_PORTS(NP_A), .DATA_BYTES(DB), .PORT_SEL_WIDTH(PSW), .CNT_WIDTH(CW_A)) dut_a (
    .core_clk_ifc(clk), .core_areset_ifc(rst_a), .egr(ifa),
    .port_enable(en_a), .cnts_clear(clr_a),
    .fwd_pkt_cnt(fwd_a), .dis_drop_cnt(dis_a), .bad_sel_drop_cnt(bad_a));

  p4_router_egress_demux #(.NUM_PORTS(NP_B), .DATA_BYTES(DB), .PORT_SEL_WIDTH(PSW), .CNT_WIDTH(CW_B)) dut_b (
    .core_clk_ifc(clk), .core_areset_ifc(rst_b), .egr(ifb),
    .port_enable(en_b), .cnts_clear(clr_b),
    .fwd_pkt_cnt(fwd_b), .dis_drop_cnt(dis_b), .bad_sel_drop_cnt(bad_b));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        vld;
    logic [1:0]  user;
    logic        last;
    logic [63:0] data;
    logic [7:0]  keep;
    logic [3:0]  en;
    logic        exp_rdy;
    logic [3:0]  exp_ovld;
    int          exp_port;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic [1:0] user, input logic last,
                              input logic [63:0] data, input logic [7:0] keep, input logic [3:0] en,
                              input logic rdy, input logic [3:0] ovld, input int port);
    vec_t v;
    v.vld = vld; v.user = user; v.last = last; v.data = data; v.keep = keep;
    v.en = en; v.exp_rdy = rdy; v.exp_ovld = ovld; v.exp_port = port;
    return v;
  endfunction

  // One beat on instance A: ready checked before the edge, outputs after it.
  task automatic apply_a(input vec_t v, input string tag);
    @(negedge clk);
    ifa.in_tvalid = v.vld; ifa.in_tuser = v.user; ifa.in_tlast = v.last;
    ifa.in_tdata = v.data; ifa.in_tkeep = v.keep; en_a = v.en;
    #1;
    chk({tag, "_rdy"}, 64'(ifa.in_tready), 64'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, "_ovld"}, 64'(ifa.out_tvalid), 64'(v.exp_ovld));
    if (v.exp_port >= 0) begin
      chk({tag, "_data"}, ifa.out_tdata[v.exp_port*64 +: 64], v.data);
      chk({tag, "_keep"}, 64'(ifa.out_tkeep[v.exp_port*8 +: 8]), 64'(v.keep));
      chk({tag, "_last"}, 64'(ifa.out_tlast[v.exp_port]), 64'(v.last));
    end
  endtask

  // One beat on instance B with all ports enabled and ready.
  task automatic apply_b(input logic [1:0] user, input logic last, input logic [63:0] data,
                         input logic clr, input logic [2:0] exp_ovld, input int port, input string tag);
    @(negedge clk);
    ifb.in_tvalid = 1'b1; ifb.in_tuser = user; ifb.in_tlast = last;
    ifb.in_tdata = data; ifb.in_tkeep = 8'hFF; clr_b = clr;
    #1;
    chk({tag, "_rdy"}, 64'(ifb.in_tready), 64'd1);
    @(posedge clk);
    #1;
    ifb.in_tvalid = 1'b0; clr_b = 1'b0;
    chk({tag, "_ovld"}, 64'(ifb.out_tvalid), 64'(exp_ovld));
    if (port >= 0) begin
      chk({tag, "_data"}, ifb.out_tdata[port*64 +: 64], data);
    end
  endtask

  vec_t vecs[$];
  int   beat, cyc, got;
  logic m_vld, ordy1, exp_rdy, acc;
  logic [63:0] base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; en_a = 4'hF; en_b = 3'b111; clr_a = 1'b0; clr_b = 1'b0;
    ifa.in_tvalid = 1'b0; ifa.in_tuser = '0; ifa.in_tlast = 1'b0; ifa.in_tdata = '0;
    ifa.in_tkeep = '0; ifa.out_tready = 4'hF;
    ifb.in_tvalid = 1'b0; ifb.in_tuser = '0; ifb.in_tlast = 1'b0; ifb.in_tdata = '0;
    ifb.in_tkeep = '0; ifb.out_tready = 3'b111;

    // Reset state
    #12;
    chk("rst_ovld", 64'(ifa.out_tvalid), 64'd0);
    chk("rst_rdy", 64'(ifa.in_tready), 64'd0);
    chk("rst_data", ifa.out_tdata[63:0], 64'd0);
    chk("rst_bad", 64'(bad_a), 64'd0);
    for (int p = 0; p < NP_A; p++) chk("rst_fwd", 64'(fwd_a[p*CW_A +: CW_A]), 64'd0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk);

    // Forwarding and disabled-port drop vectors
    vecs.push_back(mk(1'b1, 2'd2, 1'b0, 64'hA0A0_0000_0000_0001, 8'hFF, 4'hF, 1'b1, 4'b0100, 2));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 64'hA0A0_0000_0000_0002, 8'hFF, 4'hF, 1'b1, 4'b0100, 2));
    vecs.push_back(mk(1'b1, 2'd0, 1'b1, 64'hA0A0_0000_0000_0003, 8'h0F, 4'hF, 1'b1, 4'b0100, 2));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 64'hB0B0_0000_0000_0001, 8'hFF, 4'hF, 1'b1, 4'b0001, 0));
    vecs.push_back(mk(1'b1, 2'd3, 1'b0, 64'hB0B0_0000_0000_0002, 8'hFF, 4'hF, 1'b1, 4'b0001, 0));
    vecs.push_back(mk(1'b1, 2'd0, 1'b1, 64'hB0B0_0000_0000_0003, 8'h03, 4'hF, 1'b1, 4'b0001, 0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 64'h0,                   8'h00, 4'hF, 1'b1, 4'b0000, -1));
    vecs.push_back(mk(1'b1, 2'd2, 1'b0, 64'hC0C0_0000_0000_0001, 8'hFF, 4'b1011, 1'b1, 4'b0000, -1));
    vecs.push_back(mk(1'b1, 2'd1, 1'b0, 64'hC0C0_0000_0000_0002, 8'hFF, 4'b1011, 1'b1, 4'b0000, -1));
    vecs.push_back(mk(1'b1, 2'd1, 1'b0, 64'hC0C0_0000_0000_0003, 8'hFF, 4'b1011, 1'b1, 4'b0000, -1));
    vecs.push_back(mk(1'b1, 2'd0, 1'b1, 64'hC0C0_0000_0000_0004, 8'hFF, 4'b1011, 1'b1, 4'b0000, -1));
    vecs.push_back(mk(1'b1, 2'd3, 1'b1, 64'hD0D0_0000_0000_0001, 8'h81, 4'b1011, 1'b1, 4'b1000, 3));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 64'h0,                   8'h00, 4'b1011, 1'b1, 4'b0000, -1));
    for (int i = 0; i < vecs.size(); i++) apply_a(vecs[i], $sformatf("v%0d", i));
    chk("fwd2", 64'(fwd_a[2*CW_A +: CW_A]), 64'd1);
    chk("fwd0", 64'(fwd_a[0*CW_A +: CW_A]), 64'd1);
    chk("fwd3", 64'(fwd_a[3*CW_A +: CW_A]), 64'd1);
    chk("fwd1", 64'(fwd_a[1*CW_A +: CW_A]), 64'd0);
    chk("dis2", 64'(dis_a[2*CW_A +: CW_A]), 64'd1);
    chk("dis1", 64'(dis_a[1*CW_A +: CW_A]), 64'd0);
    chk("bad_a", 64'(bad_a), 64'd0);

    // 8-beat frame to port 1 with toggling ready and a mid-frame disable
    base = 64'hE1E1_0000_0000_0000;
    beat = 0; cyc = 0; got = 0; m_vld = 1'b0;
    while (((beat < 8) || m_vld) && (cyc < 60)) begin
      @(negedge clk);
      ordy1 = ((cyc % 2) == 0);
      ifa.out_tready = {2'b11, ordy1, 1'b1};
      ifa.in_tvalid  = (beat < 8);
      ifa.in_tuser   = (beat == 0) ? 2'd1 : 2'd3;
      ifa.in_tlast   = (beat == 7);
      ifa.in_tdata   = base + 64'(beat);
      ifa.in_tkeep   = 8'hFF;
      en_a           = (beat >= 3) ? 4'b1101 : 4'b1111;
      #1;
      chk("t4_ovld1", 64'(ifa.out_tvalid[1]), 64'(m_vld));
      chk("t4_others", 64'(ifa.out_tvalid & 4'b1101), 64'd0);
      exp_rdy = !m_vld || ordy1;
      if (beat < 8) chk("t4_rdy", 64'(ifa.in_tready), 64'(exp_rdy));
      if (m_vld && ordy1) begin
        chk("t4_data", ifa.out_tdata[1*64 +: 64], base + 64'(got));
        chk("t4_last", 64'(ifa.out_tlast[1]), 64'(got == 7));
        got++;
      end
      acc = (beat < 8) && exp_rdy;
      if (acc) begin
        m_vld = 1'b1;
        beat++;
      end else if (ordy1) begin
        m_vld = 1'b0;
      end
      cyc++;
    end
    @(negedge clk);
    ifa.in_tvalid = 1'b0; ifa.out_tready = 4'hF; en_a = 4'hF;
    chk("t4_beats", 64'(got), 64'd8);
    chk("t4_fwd1", 64'(fwd_a[1*CW_A +: CW_A]), 64'd1);

    // Reset in the middle of a frame to port 2
    apply_a(mk(1'b1, 2'd2, 1'b0, 64'hF0F0_0000_0000_0001, 8'hFF, 4'hF, 1'b1, 4'b0100, 2), "t5a");
    apply_a(mk(1'b1, 2'd0, 1'b0, 64'hF0F0_0000_0000_0002, 8'hFF, 4'hF, 1'b1, 4'b0100, 2), "t5b");
    @(negedge clk);
    ifa.in_tvalid = 1'b1; ifa.in_tdata = 64'hF0F0_0000_0000_0003; ifa.in_tuser = 2'd0;
    rst_a = 1'b1;
    #1;
    chk("t5_ovld", 64'(ifa.out_tvalid), 64'd0);
    chk("t5_rdy", 64'(ifa.in_tready), 64'd0);
    chk("t5_bad", 64'(bad_a), 64'd0);
    for (int p = 0; p < NP_A; p++) begin
      chk("t5_fwd", 64'(fwd_a[p*CW_A +: CW_A]), 64'd0);
      chk("t5_dis", 64'(dis_a[p*CW_A +: CW_A]), 64'd0);
    end
    ifa.in_tvalid = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    @(posedge clk);
    apply_a(mk(1'b1, 2'd1, 1'b0, 64'h5151_0000_0000_0001, 8'hFF, 4'hF, 1'b1, 4'b0010, 1), "t5c");
    apply_a(mk(1'b1, 2'd2, 1'b1, 64'h5151_0000_0000_0002, 8'h3F, 4'hF, 1'b1, 4'b0010, 1), "t5d");
    apply_a(mk(1'b0, 2'd0, 1'b0, 64'h0, 8'h00, 4'hF, 1'b1, 4'b0000, -1), "t5e");
    chk("t5_fwd1", 64'(fwd_a[1*CW_A +: CW_A]), 64'd1);
    chk("t5_fwd2", 64'(fwd_a[2*CW_A +: CW_A]), 64'd0);

    // Out-of-range select on the 3-port instance
    apply_b(2'd3, 1'b0, 64'h3333_0000_0000_0001, 1'b0, 3'b000, -1, "t3a");
    apply_b(2'd0, 1'b1, 64'h3333_0000_0000_0002, 1'b0, 3'b000, -1, "t3b");
    chk("t3_bad", 64'(bad_b), 64'd1);
    for (int p = 0; p < NP_B; p++) begin
      chk("t3_fwd", 64'(fwd_b[p*CW_B +: CW_B]), 64'd0);
      chk("t3_dis", 64'(dis_b[p*CW_B +: CW_B]), 64'd0);
    end

    // Counter saturation at 3 and clear priority over a same-cycle increment
    for (int k = 0; k < 3; k++) apply_b(2'd0, 1'b1, 64'h6000 + 64'(k), 1'b0, 3'b001, 0, "t6");
    chk("t6_fwd_max", 64'(fwd_b[0 +: CW_B]), 64'd3);
    apply_b(2'd0, 1'b1, 64'h6100, 1'b0, 3'b001, 0, "t6_sat");
    chk("t6_fwd_hold", 64'(fwd_b[0 +: CW_B]), 64'd3);
    apply_b(2'd0, 1'b1, 64'h6200, 1'b1, 3'b001, 0, "t6_clr");
    chk("t6_fwd_clr", 64'(fwd_b[0 +: CW_B]), 64'd0);
    chk("t6_bad_clr", 64'(bad_b), 64'd0);
    apply_b(2'd0, 1'b1, 64'h6300, 1'b0, 3'b001, 0, "t6_post");
    chk("t6_fwd_post", 64'(fwd_b[0 +: CW_B]), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
